// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle for mips_mem_arbiter: fetch and load/store requester channels plus the memory port.
// slave is the arbiter's view; master is the core/memory side that surrounds it.
interface mips_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  inst_req_valid;
  logic                  inst_req_ready;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  inst_rdata_valid;
  logic                  inst_rdata_ready;
  logic [DATA_WIDTH-1:0] inst_rdata;

  logic                  data_req_valid;
  logic                  data_req_ready;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic                  data_wen;
  logic [STRB_WIDTH-1:0] data_wstrb;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic                  data_rdata_valid;
  logic                  data_rdata_ready;
  logic [DATA_WIDTH-1:0] data_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rsp_valid;
  logic                  mem_rsp_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  inst_req_valid, inst_addr, inst_rdata_ready,
    output inst_req_ready, inst_rdata_valid, inst_rdata,
    input  data_req_valid, data_addr, data_wen, data_wstrb, data_wdata, data_rdata_ready,
    output data_req_ready, data_rdata_valid, data_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport master (
    output inst_req_valid, inst_addr, inst_rdata_ready,
    input  inst_req_ready, inst_rdata_valid, inst_rdata,
    output data_req_valid, data_addr, data_wen, data_wstrb, data_wdata, data_rdata_ready,
    input  data_req_ready, data_rdata_valid, data_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store, one transaction at a time.
// Optional: define MIPS_ARB_RR_EN for round-robin arbitration instead of fixed data-over-fetch.
module mips_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic               mips_cpu_clk,
  input logic               mips_cpu_reset,
  mips_mem_arbiter_if.slave bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {StIdle, StReqI, StReqD, StRspI, StRspD} state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wen;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic w_idle;
  logic w_grant_d;
  logic w_acc_i;
  logic w_acc_d;

`ifdef MIPS_ARB_RR_EN
  logic r_last_grant;  // 1 = data won the previous acceptance
  assign w_grant_d = bus.data_req_valid & (~bus.inst_req_valid | ~r_last_grant);
`else
  assign w_grant_d = bus.data_req_valid;
`endif

  assign w_idle             = (r_state == StIdle) & ~mips_cpu_reset;
  assign bus.data_req_ready = w_idle & w_grant_d;
  assign bus.inst_req_ready = w_idle & ~w_grant_d & bus.inst_req_valid;
  assign w_acc_d            = bus.data_req_valid & bus.data_req_ready;
  assign w_acc_i            = bus.inst_req_valid & bus.inst_req_ready;

  always_ff @(posedge mips_cpu_clk) begin
    if (mips_cpu_reset) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wstrb <= '0;
      r_wdata <= '0;
`ifdef MIPS_ARB_RR_EN
      r_last_grant <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_acc_d) begin
            r_addr  <= bus.data_addr;
            r_wen   <= bus.data_wen;
            r_wstrb <= bus.data_wstrb;
            r_wdata <= bus.data_wdata;
            r_state <= StReqD;
`ifdef MIPS_ARB_RR_EN
            r_last_grant <= 1'b1;
`endif
          end else if (w_acc_i) begin
            r_addr  <= bus.inst_addr;
            r_wen   <= 1'b0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_state <= StReqI;
`ifdef MIPS_ARB_RR_EN
            r_last_grant <= 1'b0;
`endif
          end
        end
        StReqI: if (bus.mem_req_ready) r_state <= StRspI;
        // Stores have no response phase.
        StReqD: if (bus.mem_req_ready) r_state <= r_wen ? StIdle : StRspD;
        StRspI: if (bus.mem_rsp_valid & bus.mem_rsp_ready) r_state <= StIdle;
        StRspD: if (bus.mem_rsp_valid & bus.mem_rsp_ready) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.mem_req_valid = (r_state == StReqI) | (r_state == StReqD);
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wen       = r_wen;
  assign bus.mem_wstrb     = r_wstrb;
  assign bus.mem_wdata     = r_wdata;

  assign bus.mem_rsp_ready = (r_state == StRspI) ? bus.inst_rdata_ready :
                             (r_state == StRspD) ? bus.data_rdata_ready : 1'b0;

  assign bus.inst_rdata_valid = (r_state == StRspI) & bus.mem_rsp_valid;
  assign bus.inst_rdata       = (r_state == StRspI) ? bus.mem_rdata : '0;
  assign bus.data_rdata_valid = (r_state == StRspD) & bus.mem_rsp_valid;
  assign bus.data_rdata       = (r_state == StRspD) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: directed stimulus pushes expected memory requests and
// read data into queues; a monitor pops and compares on every handshake.
module tb_mips_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mem_t        exp_mem[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  logic [31:0] mem_arr[logic [31:0]];
  int          req_stall = 0;
  logic        rsp_pend = 1'b0;
  logic [31:0] rsp_data = '0;

  mips_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mips_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .mips_cpu_clk  (clk),
    .mips_cpu_reset(rst),
    .bus           (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s got unexpected event expected none", name);
  endtask

  function automatic mem_t mk(input logic [31:0] a, input logic w, input logic [3:0] s,
                              input logic [31:0] d);
    mem_t m;
    m.addr = a; m.wen = w; m.wstrb = s; m.wdata = d;
    return m;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 32'h0;
  endfunction

  // Memory model: req_stall cycles of mem_req_ready low, read data one cycle after acceptance.
  initial begin
    logic [31:0] cur;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(negedge clk);
      if (rst) rsp_pend = 1'b0;
      bus.mem_rsp_valid = rsp_pend;
      bus.mem_rdata     = rsp_pend ? rsp_data : 32'h0;
      bus.mem_req_ready = (req_stall == 0);
      #1;
      if (!rst) begin
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          if (bus.mem_wen) begin
            cur = mem_rd(bus.mem_addr);
            for (int b = 0; b < 4; b++)
              if (bus.mem_wstrb[b]) cur[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            mem_arr[bus.mem_addr] = cur;
          end else begin
            rsp_pend = 1'b1;
            rsp_data = mem_rd(bus.mem_addr);
          end
        end else if (bus.mem_rsp_valid && bus.mem_rsp_ready) begin
          rsp_pend = 1'b0;
        end else if (bus.mem_req_valid && req_stall > 0) begin
          req_stall--;
        end
      end
    end
  end

  // Monitor
  initial begin
    mem_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          if (exp_mem.size() == 0) fail_evt("mem_req_unexpected");
          else begin
            e = exp_mem.pop_front();
            chk("mem_addr", bus.mem_addr, e.addr);
            chk("mem_wen", 32'(bus.mem_wen), 32'(e.wen));
            chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(e.wstrb));
            chk("mem_wdata", bus.mem_wdata, e.wdata);
          end
        end
        if (bus.inst_rdata_valid) begin
          if (exp_i.size() == 0) fail_evt("inst_rdata_unexpected");
          else if (bus.inst_rdata_ready) chk("inst_rdata", bus.inst_rdata, exp_i.pop_front());
        end
        if (bus.data_rdata_valid) begin
          if (exp_d.size() == 0) fail_evt("data_rdata_unexpected");
          else if (bus.data_rdata_ready) chk("data_rdata", bus.data_rdata, exp_d.pop_front());
        end
      end
    end
  end

  task automatic do_inst(input logic [31:0] a, output int acc);
    int n = 0;
    bus.inst_addr      = a;
    bus.inst_req_valid = 1'b1;
    #1;
    while (!bus.inst_req_ready && n < 100) begin @(negedge clk); #1; n++; end
    chk("inst_req_ready", 32'(bus.inst_req_ready), 32'h1);
    acc = cyc;
    @(negedge clk);
    bus.inst_req_valid = 1'b0;
  endtask

  task automatic do_data(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, output int acc);
    int n = 0;
    bus.data_addr      = a;
    bus.data_wen       = w;
    bus.data_wstrb     = s;
    bus.data_wdata     = d;
    bus.data_req_valid = 1'b1;
    #1;
    while (!bus.data_req_ready && n < 100) begin @(negedge clk); #1; n++; end
    chk("data_req_ready", 32'(bus.data_req_ready), 32'h1);
    acc = cyc;
    @(negedge clk);
    bus.data_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_mem.size() + exp_i.size() + exp_d.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(exp_mem.size() + exp_i.size() + exp_d.size()), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          a0, a1, a2, last, n;
    logic [3:0]  seq;

    mem_arr[32'h40]  = 32'h8C080004;
    mem_arr[32'h44]  = 32'h2108FFFF;
    mem_arr[32'h100] = 32'h11112222;
    mem_arr[32'h0C]  = 32'hDEADBEEF;
    mem_arr[32'h10]  = 32'h12345678;
    mem_arr[32'h200] = 32'h0200AAAA;
    mem_arr[32'h300] = 32'h0300BBBB;

    // Reset held with both requesters valid
    rst = 1'b1;
    bus.inst_rdata_ready = 1'b1;
    bus.data_rdata_ready = 1'b1;
    bus.inst_addr = 32'h40;
    bus.data_addr = 32'h100;
    bus.data_wen = 1'b0;
    bus.data_wstrb = 4'h0;
    bus.data_wdata = 32'h0;
    bus.inst_req_valid = 1'b1;
    bus.data_req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_inst_ready", 32'(bus.inst_req_ready), 32'h0);
      chk("rst_data_ready", 32'(bus.data_req_ready), 32'h0);
      chk("rst_mem_valid", 32'(bus.mem_req_valid), 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wen", 32'(bus.mem_wen), 32'h0);
      chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_mem_rsp_ready", 32'(bus.mem_rsp_ready), 32'h0);
      chk("rst_inst_rvalid", 32'(bus.inst_rdata_valid), 32'h0);
      chk("rst_data_rvalid", 32'(bus.data_rdata_valid), 32'h0);
      chk("rst_inst_rdata", bus.inst_rdata, 32'h0);
      chk("rst_data_rdata", bus.data_rdata, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_mem.push_back(mk(32'h100, 1'b0, 4'h0, 32'h0));
    exp_d.push_back(32'h11112222);
    #1;
    chk("rel_data_ready", 32'(bus.data_req_ready), 32'h1);
    chk("rel_inst_ready", 32'(bus.inst_req_ready), 32'h0);
    @(negedge clk);
    bus.inst_req_valid = 1'b0;  // fetch withdrawn before grant: must leave no trace
    bus.data_req_valid = 1'b0;
    wait_idle("reset_release");

    // Single fetch with cycle-accurate timing
    exp_mem.push_back(mk(32'h40, 1'b0, 4'h0, 32'h0));
    exp_i.push_back(32'h8C080004);
    do_inst(32'h40, a0);
    #1;
    chk("fetch_c1_valid", 32'(bus.mem_req_valid), 32'h1);
    chk("fetch_c1_addr", bus.mem_addr, 32'h40);
    chk("fetch_c1_wen", 32'(bus.mem_wen), 32'h0);
    @(negedge clk);
    #1;
    chk("fetch_c2_rvalid", 32'(bus.inst_rdata_valid), 32'h1);
    chk("fetch_c2_rdata", bus.inst_rdata, 32'h8C080004);
    chk("fetch_c2_data_rvalid", 32'(bus.data_rdata_valid), 32'h0);
    wait_idle("fetch");

    // Store with 4 cycles of memory back-pressure
    req_stall = 4;
    exp_mem.push_back(mk(32'h0C, 1'b1, 4'hF, 32'h0));
    do_data(32'h0C, 1'b1, 4'hF, 32'h0, a0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_valid", 32'(bus.mem_req_valid), 32'h1);
      chk("stall_addr", bus.mem_addr, 32'h0C);
      chk("stall_wen", 32'(bus.mem_wen), 32'h1);
      chk("stall_wstrb", 32'(bus.mem_wstrb), 32'hF);
      chk("stall_wdata", bus.mem_wdata, 32'h0);
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    chk("store_done_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("store_no_inst_rv", 32'(bus.inst_rdata_valid), 32'h0);
    chk("store_no_data_rv", 32'(bus.data_rdata_valid), 32'h0);
    wait_idle("store_stall");

    // Partial store then back-to-back loads; checks byte enables and turnaround
    exp_mem.push_back(mk(32'h10, 1'b1, 4'h3, 32'hAAAA5555));
    exp_mem.push_back(mk(32'h0C, 1'b0, 4'h0, 32'h0));
    exp_d.push_back(32'h00000000);
    exp_mem.push_back(mk(32'h10, 1'b0, 4'h0, 32'h0));
    exp_d.push_back(32'h12345555);
    do_data(32'h10, 1'b1, 4'h3, 32'hAAAA5555, a0);
    do_data(32'h0C, 1'b0, 4'h0, 32'h0, a1);
    do_data(32'h10, 1'b0, 4'h0, 32'h0, a2);
    chk("store_turnaround", 32'(a1 - a0), 32'd2);
    chk("read_turnaround", 32'(a2 - a1), 32'd3);
    wait_idle("store_load");

    // Load response back-pressured by the LSU
    bus.data_rdata_ready = 1'b0;
    exp_mem.push_back(mk(32'h300, 1'b0, 4'h0, 32'h0));
    exp_d.push_back(32'h0300BBBB);
    do_data(32'h300, 1'b0, 4'h0, 32'h0, a0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bp_rvalid", 32'(bus.data_rdata_valid), 32'h1);
      chk("bp_rsp_ready", 32'(bus.mem_rsp_ready), 32'h0);
      chk("bp_rdata", bus.data_rdata, 32'h0300BBBB);
      @(negedge clk);
    end
    bus.data_rdata_ready = 1'b1;
    #1;
    chk("bp_rsp_ready_rise", 32'(bus.mem_rsp_ready), 32'h1);
    @(negedge clk);
    #1;
    chk("bp_done_rvalid", 32'(bus.data_rdata_valid), 32'h0);
    wait_idle("rsp_backpressure");

    // Reset while a fetch waits in the request phase
    req_stall = 100;
    do_inst(32'h40, a0);
    rst = 1'b1;
    #1;
    chk("midrst_pre_valid", 32'(bus.mem_req_valid), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    req_stall = 0;
    #1;
    chk("midrst_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("midrst_addr", bus.mem_addr, 32'h0);
    chk("midrst_inst_rv", 32'(bus.inst_rdata_valid), 32'h0);
    @(negedge clk);
    exp_mem.push_back(mk(32'h44, 1'b0, 4'h0, 32'h0));
    exp_i.push_back(32'h2108FFFF);
    do_inst(32'h44, a0);
    wait_idle("midrst_refetch");

    // Both requesters valid continuously
`ifdef MIPS_ARB_RR_EN
    seq = 4'b0101;
`else
    seq = 4'b1111;
`endif
    for (int g = 0; g < 4; g++) begin
      if (seq[g]) begin
        exp_mem.push_back(mk(32'h300, 1'b0, 4'h0, 32'h0));
        exp_d.push_back(32'h0300BBBB);
      end else begin
        exp_mem.push_back(mk(32'h200, 1'b0, 4'h0, 32'h0));
        exp_i.push_back(32'h0200AAAA);
      end
    end
    bus.inst_addr = 32'h200;
    bus.data_addr = 32'h300;
    bus.data_wen = 1'b0;
    bus.data_wstrb = 4'h0;
    bus.data_wdata = 32'h0;
    bus.inst_req_valid = 1'b1;
    bus.data_req_valid = 1'b1;
    last = 0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      #1;
      while (!(bus.inst_req_ready || bus.data_req_ready) && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("grant_seen", 32'(bus.inst_req_ready | bus.data_req_ready), 32'h1);
      chk("grant_owner", 32'(bus.data_req_ready), 32'(seq[g]));
      if (g > 0) chk("grant_gap", 32'(cyc - last), 32'd3);
      last = cyc;
      @(negedge clk);
    end
    bus.inst_req_valid = 1'b0;
    bus.data_req_valid = 1'b0;
    wait_idle("contention");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares the single memory port of the multi-cycle MIPS core between the instruction-fetch requester and the load/store requester.
- Sits between the core's fetch/LSU interfaces and the unified instruction/data memory inside mips_cpu_top.
- Grants one transaction at a time, registers it, drives the memory request, then routes the read response back to the owner.
- Exactly one transaction is outstanding at any time.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses; the strobe width is DATA_WIDTH/8

Ports:
mips_cpu_clk  in  1  clock; all state changes on the rising edge
mips_cpu_reset  in  1  reset, synchronous, active-high
inst_req_valid  in  1  fetch request valid
inst_req_ready  out  1  fetch request accepted this cycle
inst_addr  in  ADDR_WIDTH  fetch address
inst_rdata_valid  out  1  fetch read data valid
inst_rdata_ready  in  1  fetch requester can take data
inst_rdata  out  DATA_WIDTH  fetch read data
data_req_valid  in  1  load/store request valid
data_req_ready  out  1  load/store request accepted this cycle
data_addr  in  ADDR_WIDTH  load/store address
data_wen  in  1  1 = store, 0 = load
data_wstrb  in  DATA_WIDTH/8  store byte enables
data_wdata  in  DATA_WIDTH  store data
data_rdata_valid  out  1  load data valid
data_rdata_ready  in  1  LSU can take data
data_rdata  out  DATA_WIDTH  load data
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_WIDTH  memory address
mem_wen  out  1  memory write enable
mem_wstrb  out  DATA_WIDTH/8  memory byte enables
mem_wdata  out  DATA_WIDTH  memory write data
mem_rsp_valid  in  1  memory read data valid
mem_rsp_ready  out  1  arbiter can take read data
mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- FSM states: IDLE, REQ_I, REQ_D, RSP_I, RSP_D. Reset state is IDLE.
- Reset, including mid-transaction: FSM returns to IDLE, the in-flight transaction is dropped, and all latched address/data/strobe/wen registers are cleared to 0.
- Output reset values: every *_ready, *_valid, mem_wen and mem_wstrb output is 0; mem_addr, mem_wdata, inst_rdata and data_rdata are 0.
- IDLE arbitration:
  - Data has fixed priority over fetch.
  - In IDLE, the winning requester's *_req_ready is driven combinationally to 1. The loser's ready is 0. No ready is asserted in any other state.
- Acceptance is a valid & ready handshake in IDLE. On acceptance:
  - addr, wen, wstrb and wdata are latched; a fetch latches wen=0, wstrb=0, wdata=0.
  - FSM moves to REQ_I or REQ_D.
- REQ_x:
  - mem_req_valid=1; mem_* fields are driven from the latched registers and stay stable until mem_req_ready.
  - On mem_req_ready: a store (wen=1) returns to IDLE with no response phase; a load or fetch moves to RSP_x.
- RSP_x:
  - The owner's *_rdata_valid equals mem_rsp_valid, and its *_rdata equals mem_rdata.
  - mem_rsp_ready equals the owner's *_rdata_ready.
  - When mem_rsp_valid & mem_rsp_ready, return to IDLE.
  - The non-owner's rdata_valid stays 0.
- Timing:
  - Minimum read latency: accept in cycle N, mem_req_valid in N+1, earliest response in N+2, next accept in N+3.
  - Minimum store turnaround: 2 cycles.
- Requesters must hold valid and payload stable until ready. The arbiter does not check this.
- A requester that drops valid before its grant is never serviced and leaves no side effects.
- Memory stalls (mem_req_ready or mem_rsp_valid held low) hold the FSM in its current state indefinitely. There is no timeout.
- Back-to-back requests from the same requester are legal. Each one passes through IDLE.
- mem_rsp_valid outside RSP_x is ignored and mem_rsp_ready is 0.

Optional Feature:
Macro MIPS_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. A 1-bit last_grant register is cleared to 0 (fetch) on reset and updated on every acceptance.
  - When both requesters are valid in IDLE, the grant goes to the one that was not granted last. With a single requester, that requester wins.
- Undefined: fixed data-over-fetch priority. No last_grant register exists.

Test Plan:
- Reset held 3 cycles with both req_valid=1 -> no ready, mem_req_valid=0, all outputs 0. Release -> data granted in the first IDLE cycle.
- Fetch only, inst_addr=0x00000040, memory returns 0x8C080004 one cycle after mem_req_ready:
  - inst_req_ready in cycle 0, mem_addr=0x40 with mem_wen=0 in cycle 1.
  - inst_rdata=0x8C080004 valid in cycle 2; data_rdata_valid stays 0.
- Store data_addr=0x0C, wdata=0, wstrb=0xF, mem_req_ready held low 4 cycles:
  - mem_* fields stable for all 4 cycles.
  - After ready: IDLE, no rdata_valid on either port.
- Both valid continuously, each read served with 1-cycle memory latency:
  - Default build: data granted every time, fetch starved.
  - With MIPS_ARB_RR_EN: grants alternate D,I,D,I starting with D.
- Load in RSP_D with data_rdata_ready=0 for 2 cycles and mem_rsp_valid=1 -> mem_rsp_ready=0, FSM stays in RSP_D, completes on the cycle ready rises.
- mips_cpu_reset asserted during REQ_I -> next cycle IDLE, mem_req_valid=0. A fresh fetch is then serviced normally.
